qq_sorted_node: RTL and testbench

//  Parametrised QuickQueue node: a DEPTH-entry sorted priority queue held in

---
 rtl/qq_pkg.sv | 12 +
 rtl/qq_cell.sv | 34 +++
 rtl/qq_sorted_node.sv | 103 ++++++++++
 tb/tb_qq_sorted_node.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/qq_pkg.sv
// qq_pkg: shared op/state enums and ordering helpers for the QuickQueue node
package qq_pkg;
  localparam int MAX_W = 64;
  typedef enum logic [1:0] {OP_IDLE, OP_ENQ, OP_DEQ, OP_REPL} qq_op_e;
  typedef enum logic [1:0] {ST_EMPTY, ST_PARTIAL, ST_FULL} qq_state_e;
  function automatic logic [MAX_W-1:0] empty_val(input logic min_first);
    return min_first ? '1 : '0;
  endfunction
  function automatic logic better(input logic [MAX_W-1:0] a, input logic [MAX_W-1:0] b, input logic min_first);
    return min_first ? (a < b) : (a > b);
  endfunction
endpackage

// File: rtl/qq_cell.sv
// qq_cell: one sorted-queue entry choosing hold, shift-left, shift-right or load each clock
module qq_cell
  import qq_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter bit MIN_FIRST = 1,
  parameter bit HEAD      = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  qq_op_e            op,
  input  logic [DATA_W-1:0] word,
  input  logic [DATA_W-1:0] left,
  input  logic [DATA_W-1:0] right,
  input  logic              ins_prev,
  input  logic              ins_here,
  input  logic              ins_next,
  output logic [DATA_W-1:0] data
);
  localparam logic [DATA_W-1:0] EMPTY = DATA_W'(empty_val(MIN_FIRST));
  logic [DATA_W-1:0] nxt;
  always_comb begin
    nxt = op == OP_ENQ  ? (ins_prev ? left : ins_here ? word : data) :
          op == OP_DEQ  ? right :
          op == OP_REPL ? ((ins_here && !HEAD) ? data : ins_next ? word : right) :
          data;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) data <= EMPTY;
    else if (flush) data <= EMPTY;
    else data <= nxt;
  end
endmodule

// File: rtl/qq_sorted_node.sv
// qq_sorted_node: register-based sorted priority queue node with spill/refill chaining
module qq_sorted_node
  import qq_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int DEPTH     = 16,
  parameter bit MIN_FIRST = 1,
  parameter int CNT_W     = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush_i,
  input  logic              enq_valid_i,
  input  logic [DATA_W-1:0] enq_data_i,
  output logic              enq_ready_o,
  output logic              deq_valid_o,
  output logic [DATA_W-1:0] deq_data_o,
  input  logic              deq_ready_i,
  output logic              spill_valid_o,
  output logic [DATA_W-1:0] spill_data_o,
  input  logic              spill_ready_i,
  input  logic              refill_valid_i,
  input  logic [DATA_W-1:0] refill_data_i,
  output logic              refill_ready_o,
  output logic [CNT_W-1:0]  count_o,
  output logic              full_o,
  output logic              empty_o
);
  localparam logic [DATA_W-1:0] EMPTY = DATA_W'(empty_val(MIN_FIRST));
  logic [DATA_W-1:0] e [DEPTH];
  logic [DATA_W-1:0] ext [DEPTH+1];
  logic [DATA_W-1:0] word, spill_word;
  logic [DEPTH:0]    ins;
  logic [CNT_W-1:0]  count, cnt_nx;
  qq_state_e         state, state_nx;
  qq_op_e            op, cop;
  logic              enq_fire, deq_fire, spill_go;
  assign full_o         = state == ST_FULL;
  assign empty_o        = state == ST_EMPTY;
  assign count_o        = count;
  assign deq_valid_o    = !empty_o;
  assign deq_data_o     = e[0];
  assign deq_fire       = deq_valid_o & deq_ready_i;
  assign enq_ready_o    = !full_o | deq_fire | spill_ready_i;
  assign enq_fire       = enq_valid_i & enq_ready_o;
  assign refill_ready_o = deq_fire & !enq_valid_i & refill_valid_i;
  assign op   = (enq_fire && deq_fire) ? OP_REPL : enq_fire ? OP_ENQ : deq_fire ? OP_DEQ : OP_IDLE;
  assign cop  = refill_ready_o ? OP_REPL : op;
  assign word = refill_ready_o ? refill_data_i : enq_data_i;
  assign spill_go   = op == OP_ENQ && full_o;
  assign spill_word = ins[DEPTH-1] ? e[DEPTH-1] : enq_data_i;
  assign ins[DEPTH] = 1'b1;
  assign ext[DEPTH] = EMPTY;
  for (genvar i = 0; i < DEPTH; i++) begin : g_cell
    assign ext[i] = e[i];
    assign ins[i] = better(MAX_W'(word), MAX_W'(e[i]), MIN_FIRST) | (CNT_W'(i) >= count);
    qq_cell #(
      .DATA_W   (DATA_W),
      .MIN_FIRST(MIN_FIRST),
      .HEAD     (i == 0)
    ) u_cell (
      .clk     (clk),
      .rst_n   (rst_n),
      .flush   (flush_i),
      .op      (cop),
      .word    (word),
      .left    (e[(i > 0) ? i - 1 : 0]),
      .right   (ext[i+1]),
      .ins_prev((i > 0) & ins[(i > 0) ? i - 1 : 0]),
      .ins_here(ins[i]),
      .ins_next(ins[i+1]),
      .data    (e[i])
    );
  end
  always_comb begin
    cnt_nx   = (op == OP_ENQ && !full_o) ? count + 1'b1 :
               (op == OP_DEQ && !refill_ready_o) ? count - 1'b1 : count;
    state_nx = cnt_nx == '0 ? ST_EMPTY : cnt_nx == CNT_W'(DEPTH) ? ST_FULL : ST_PARTIAL;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
      state <= ST_EMPTY;
    end else if (flush_i) begin
      count <= '0;
      state <= ST_EMPTY;
    end else begin
      count <= cnt_nx;
      state <= state_nx;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      spill_valid_o <= 1'b0;
      spill_data_o  <= '0;
    end else if (flush_i) begin
      spill_valid_o <= 1'b0;
    end else begin
      spill_valid_o <= spill_go;
      if (spill_go) spill_data_o <= spill_word;
    end
  end
endmodule

// File: tb/tb_qq_sorted_node.sv
// tb_qq_sorted_node: directed checks of ordering, spill, refill, replace and flush
module tb_qq_sorted_node;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  int total = 0;
  int bad = 0;
  logic       a_flush = 0, a_enq_v = 0, a_deq_r = 0, a_spill_r = 1, a_ref_v = 0;
  logic [7:0] a_enq_d = 0, a_ref_d = 0;
  logic       a_enq_rdy, a_deq_v, a_spill_v, a_ref_rdy, a_full, a_empty;
  logic [7:0] a_deq_d, a_spill_d;
  logic [2:0] a_cnt;
  logic       b_flush = 0, b_enq_v = 0, b_deq_r = 0;
  logic [7:0] b_enq_d = 0;
  logic       b_enq_rdy, b_deq_v, b_spill_v, b_ref_rdy, b_full, b_empty;
  logic [7:0] b_deq_d, b_spill_d;
  logic [1:0] b_cnt;
  qq_sorted_node #(.DATA_W(8), .DEPTH(4), .MIN_FIRST(1)) u_asc (
    .clk(clk), .rst_n(rst_n), .flush_i(a_flush),
    .enq_valid_i(a_enq_v), .enq_data_i(a_enq_d), .enq_ready_o(a_enq_rdy),
    .deq_valid_o(a_deq_v), .deq_data_o(a_deq_d), .deq_ready_i(a_deq_r),
    .spill_valid_o(a_spill_v), .spill_data_o(a_spill_d), .spill_ready_i(a_spill_r),
    .refill_valid_i(a_ref_v), .refill_data_i(a_ref_d), .refill_ready_o(a_ref_rdy),
    .count_o(a_cnt), .full_o(a_full), .empty_o(a_empty)
  );
  qq_sorted_node #(.DATA_W(8), .DEPTH(2), .MIN_FIRST(0)) u_dsc (
    .clk(clk), .rst_n(rst_n), .flush_i(b_flush),
    .enq_valid_i(b_enq_v), .enq_data_i(b_enq_d), .enq_ready_o(b_enq_rdy),
    .deq_valid_o(b_deq_v), .deq_data_o(b_deq_d), .deq_ready_i(b_deq_r),
    .spill_valid_o(b_spill_v), .spill_data_o(b_spill_d), .spill_ready_i(1'b1),
    .refill_valid_i(1'b0), .refill_data_i(8'h00), .refill_ready_o(b_ref_rdy),
    .count_o(b_cnt), .full_o(b_full), .empty_o(b_empty)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
    a_enq_v = 0; a_deq_r = 0; a_ref_v = 0; a_flush = 0;
    b_enq_v = 0; b_deq_r = 0; b_flush = 0;
  endtask
  task automatic a_push(input logic [7:0] d);
    a_enq_v = 1; a_enq_d = d;
    tick();
  endtask
  task automatic a_pop();
    a_deq_r = 1;
    tick();
  endtask
  task automatic b_push(input logic [7:0] d);
    b_enq_v = 1; b_enq_d = d;
    tick();
  endtask
  initial begin
    #100000;
    $display("FAIL timeout");
    $fatal(1);
  end
  initial begin
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    check("rst_cnt", a_cnt, 0);
    check("rst_empty", a_empty, 1);
    check("rst_full", a_full, 0);
    check("rst_deqv", a_deq_v, 0);
    check("rst_head", a_deq_d, 8'hff);
    check("rst_spillv", a_spill_v, 0);
    check("rst_b_head", b_deq_d, 8'h00);
    a_push(5); a_push(3); a_push(9);
    check("ord_cnt3", a_cnt, 3);
    check("ord_head3", a_deq_d, 3);
    a_pop();
    check("ord_head5", a_deq_d, 5);
    check("ord_cnt2", a_cnt, 2);
    a_pop();
    check("ord_head9", a_deq_d, 9);
    check("ord_cnt1", a_cnt, 1);
    a_pop();
    check("ord_headE", a_deq_d, 8'hff);
    check("ord_cnt0", a_cnt, 0);
    check("ord_empty", a_empty, 1);
    a_push(4); a_push(3); a_push(2); a_push(1);
    check("fill_full", a_full, 1);
    check("fill_cnt", a_cnt, 4);
    check("fill_head", a_deq_d, 1);
    a_push(0);
    check("sp0_valid", a_spill_v, 1);
    check("sp0_data", a_spill_d, 4);
    check("sp0_head", a_deq_d, 0);
    check("sp0_cnt", a_cnt, 4);
    a_push(7);
    check("sp7_valid", a_spill_v, 1);
    check("sp7_data", a_spill_d, 7);
    check("sp7_head", a_deq_d, 0);
    tick();
    check("sp_pulse", a_spill_v, 0);
    a_spill_r = 0; a_enq_v = 1; a_enq_d = 5;
    #1 check("bp_ready", a_enq_rdy, 0);
    tick();
    check("bp_head", a_deq_d, 0);
    check("bp_cnt", a_cnt, 4);
    check("bp_spill", a_spill_v, 0);
    a_spill_r = 1;
    a_pop();
    check("dr_head1", a_deq_d, 1);
    check("dr_full", a_full, 0);
    a_pop();
    check("dr_head2", a_deq_d, 2);
    a_pop();
    check("dr_head3", a_deq_d, 3);
    a_pop();
    check("dr_empty", a_empty, 1);
    a_push(2); a_push(6);
    a_enq_v = 1; a_enq_d = 4; a_deq_r = 1;
    tick();
    check("rp_head", a_deq_d, 4);
    check("rp_cnt", a_cnt, 2);
    check("rp_spill", a_spill_v, 0);
    a_pop();
    check("rp_head6", a_deq_d, 6);
    check("rp_cnt1", a_cnt, 1);
    a_deq_r = 1; a_ref_v = 1; a_ref_d = 8;
    #1 check("rf_ready", a_ref_rdy, 1);
    tick();
    check("rf_head", a_deq_d, 8);
    check("rf_cnt", a_cnt, 1);
    a_deq_r = 1; a_ref_v = 1; a_ref_d = 9; a_enq_v = 1; a_enq_d = 3;
    #1 check("rf_block", a_ref_rdy, 0);
    tick();
    check("rf_repl_head", a_deq_d, 3);
    check("rf_repl_cnt", a_cnt, 1);
    a_pop();
    check("rf_empty", a_empty, 1);
    a_enq_v = 1; a_enq_d = 5; a_deq_r = 1;
    tick();
    check("ed_cnt", a_cnt, 1);
    check("ed_head", a_deq_d, 5);
    a_flush = 1; a_enq_v = 1; a_enq_d = 1;
    tick();
    check("fl_cnt", a_cnt, 0);
    check("fl_head", a_deq_d, 8'hff);
    b_push(5); b_push(9);
    check("b_head9", b_deq_d, 9);
    check("b_full", b_full, 1);
    check("b_cnt2", b_cnt, 2);
    b_push(5);
    check("b_spv", b_spill_v, 1);
    check("b_spd", b_spill_d, 5);
    check("b_head9b", b_deq_d, 9);
    b_deq_r = 1;
    tick();
    check("b_head5", b_deq_d, 5);
    check("b_cnt1", b_cnt, 1);
    check("b_notfull", b_full, 0);
    b_push(7);
    check("b_head7", b_deq_d, 7);
    b_flush = 1; b_enq_v = 1; b_enq_d = 3;
    tick();
    check("b_fl_head", b_deq_d, 0);
    check("b_fl_cnt", b_cnt, 0);
    check("b_fl_empty", b_empty, 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
